// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between the instruction-fetch and data
// request sides. Data requests win arbitration unless a fetch has been held
// off for STARVE_MAX consecutive data completions. A watchdog abandons grants
// that stay BUSY for TIMEOUT cycles, and err latches any timeout or RAM ERROR.
module mem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);

    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_MAX);
    localparam logic [WW-1:0] WDOG_LAST  = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } state_t;

    state_t        state;
    logic [SW-1:0] streak;
    logic [WW-1:0] wdog;

    logic dreq;
    logic ram_acc;
    logic ram_err;
    logic guard_trip;

    assign dreq       = dREN | dWEN;
    assign ram_acc    = (ramstate == RAM_ACCESS);
    assign ram_err    = (ramstate == RAM_ERROR);
    // A fetch that has waited out STARVE_MAX data completions takes the next grant.
    assign guard_trip = (streak == STREAK_MAX) && iREN;

    // Read data is shared; the wait signals say which side it belongs to.
    assign iload = ramload;
    assign dload = ramload;

    // Arbitration, completion, watchdog and starvation bookkeeping.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            streak <= '0;
            wdog   <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dreq && !guard_trip) begin
                        state <= DGRANT;
                        wdog  <= '0;
                    end else if (iREN) begin
                        state <= IGRANT;
                        wdog  <= '0;
                    end
                end
                IGRANT: begin
                    if (!iREN) begin
                        state <= IDLE;
                    end else if (ram_acc) begin
                        state  <= IDLE;
                        streak <= '0;
                    end else if (ram_err || (wdog == WDOG_LAST)) begin
                        state <= IDLE;
                        err   <= 1'b1;
                    end else begin
                        wdog <= wdog + WW'(1);
                    end
                end
                DGRANT: begin
                    if (!dreq) begin
                        state <= IDLE;
                    end else if (ram_acc) begin
                        state <= IDLE;
                        if (!iREN) begin
                            streak <= '0;
                        end else if (streak != STREAK_MAX) begin
                            streak <= streak + SW'(1);
                        end
                    end else if (ram_err || (wdog == WDOG_LAST)) begin
                        state <= IDLE;
                        err   <= 1'b1;
                    end else begin
                        wdog <= wdog + WW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM drive and wait outputs follow the live request so a withdrawal drops
    // the strobes in the same cycle.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        case (state)
            IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iwait   = !(iREN && ram_acc);
            end
            DGRANT: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dwait    = !(dreq && ram_acc);
            end
            default: ;
        endcase
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequential arbiter that shares the single RAM port between the instruction-cache and data-cache request sides of the pipelined datapath. It grants one requester at a time through a registered state machine and holds the grant until RAM reports completion. Data requests have priority, with a starvation guard for fetches. A watchdog flags RAM transactions that hang.

## Interface
- STARVE_MAX, 4: consecutive data completions, with a fetch pending, after which the next grant goes to the fetch.
- TIMEOUT, 255: maximum cycles a grant may stay in BUSY before being abandoned.
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- iREN  in  1  instruction read request.
- iaddr  in  32  instruction word address.
- iload  out  32  instruction read data; equals ramload.
- iwait  out  1  instruction side stall; low only on the completion cycle.
- dREN  in  1  data read request.
- dWEN  in  1  data write request; wins over dREN if both are high.
- daddr  in  32  data address.
- dstore  in  32  data write value.
- dload  out  32  data read data; equals ramload.
- dwait  out  1  data side stall; low only on the completion cycle.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM state: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- err  out  1  sticky fault flag for a timeout or RAM ERROR.

## Operation
- States: IDLE, IGRANT, DGRANT. Reset enters IDLE.
- IDLE arbitration:
  - If a data request (dREN|dWEN) is present and the guard has not tripped, go to DGRANT.
  - Otherwise, if iREN is high, go to IGRANT.
  - The guard trips when streak==STARVE_MAX and iREN is high; IGRANT is then chosen.
- RAM drive in IDLE: ramREN=ramWEN=0, ramaddr=0, ramstore=0.
- RAM drive in IGRANT: ramREN=iREN, ramaddr=iaddr.
- RAM drive in DGRANT: ramWEN=dWEN, ramREN=dREN&~dWEN, ramaddr=daddr, ramstore=dstore.
- Completion: when the granted side sees ramstate==ACCESS, its wait goes low combinationally in that cycle and the FSM returns to IDLE.
- Request withdrawn mid-grant: if the granted request is deasserted, the RAM strobes drop the same cycle and the FSM returns to IDLE with no completion. No err.
- ramstate==ERROR while granted: set err, return to IDLE. The wait output stays high, so the requester retries naturally.
- Watchdog: a counter clears on each grant entry and increments each granted cycle without ACCESS. On reaching TIMEOUT it sets err and returns to IDLE.
- streak (width clog2(STARVE_MAX+1)):
  - Data completion with iREN high: increments, saturating at STARVE_MAX.
  - Data completion with iREN low: clears.
  - Instruction completion: clears.
- err clears only on reset.
- The non-granted side's wait stays high. iwait and dwait are 1 whenever their side is not completing, including when idle.

## Timing
- Arbitration is registered. A request first seen in IDLE in cycle N drives the RAM from cycle N+1.
- Best-case access with ACCESS on the first granted cycle: wait low in N+1, IDLE in N+2. Back-to-back accesses therefore take at least 2 cycles each.
- RAM latency L cycles of BUSY: completion in cycle N+1+L.
- Simultaneous I and D requests in IDLE: D wins unless the guard has tripped.
- Reset mid-grant forces, asynchronously:
  - state=IDLE, streak=0, watchdog=0, err=0;
  - ramREN=ramWEN=0, ramaddr=ramstore=0;
  - iwait=dwait=1.
- Watchdog boundary: with TIMEOUT=T, a grant still BUSY after T granted cycles is abandoned; ACCESS arriving on cycle T completes normally.

## Test plan
- Fetch only: iREN=1, iaddr=0x40, RAM latency 2, ramload=0x8C010004 -> ramREN high from cycle 1, iwait low in cycle 3 with iload=0x8C010004, IDLE in cycle 4.
- Simultaneous requests: iREN=1, dREN=1, daddr=0x100 in the same cycle -> DGRANT first (ramaddr=0x100). IGRANT follows after the data completion. iwait stays high throughout the data access.
- Write precedence: dREN=dWEN=1, daddr=0x200, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF, dwait low on ACCESS.
- Starvation guard with STARVE_MAX=2: continuous data requests plus iREN held high -> grant order D, D, I, D, D, I.
- Timeout with TIMEOUT=4 and ramstate held at BUSY -> err rises after 4 granted cycles, FSM returns to IDLE, the request is re-granted, and err stays 1.
- Reset mid-access: nRST low during DGRANT BUSY -> outputs immediately at their reset values. After release with dREN still high, DGRANT is re-entered one cycle later.
